fire_controller: RTL and testbench

//  Trigger-to-ammo sequencer directly upstream of the ammo saturation counter.

---
 rtl/weapons_pkg.sv | 31 +++
 rtl/cooldown_timer.sv | 38 +++
 rtl/fire_controller.sv | 168 ++++++++++++++++
 tb/tb_fire_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/weapons_pkg.sv
// Shared constants and state encoding for the weapons fire path.
package weapons_pkg;

   // One-hot ship mode that permits firing.
   localparam logic [3:0] ATTACK_MODE = 4'b0010;

   // Default reload value; matches the ammo saturation counter ceiling.
   localparam int unsigned MAX_AMMO_DEF = 500;

   // Width of the shared cooldown/reload down-counter.
   localparam int unsigned TMR_W = 8;

   // Width of the remaining-shots register (BURST <= 7).
   localparam int unsigned SHOT_W = 3;

   // 3-bit binary state encoding.
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FIRE   = 3'd1;
   localparam logic [2:0] S_COOL   = 3'd2;
   localparam logic [2:0] S_RELOAD = 3'd3;
   localparam logic [2:0] S_RWAIT  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_FIRE   = S_FIRE,
      ST_COOL   = S_COOL,
      ST_RELOAD = S_RELOAD,
      ST_RWAIT  = S_RWAIT
   } fc_state_e;

endpackage

// File: rtl/cooldown_timer.sv
// Loadable down-counter shared by the shot cooldown and the reload wait.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i into the counter (wins over en_i)
//   load_val_i  : value to load
//   en_i        : decrement by one (holds at zero)
//   done_o      : registered, high while the count equals 1
module cooldown_timer
   import weapons_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [TMR_W-1:0] cnt_q;
   logic             done_q;

   // done_q tracks (cnt_q == 1) by looking at the value being written.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (load_i) begin
         cnt_q  <= load_val_i;
         done_q <= (load_val_i == TMR_W'(1));
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q  <= cnt_q - TMR_W'(1);
         done_q <= (cnt_q == TMR_W'(2));
      end
   end

   assign done_o = done_q;

endmodule

// File: rtl/fire_controller.sv
// Trigger-to-ammo sequencer: turns trigger edges into rate-limited single or
// burst decrement pulses, flags illegal fire and sequences reloads.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   trigger        : raw fire request (level)
//   burst_mode     : 1 = BURST shots per edge, 0 = one shot
//   mode_selector  : one-hot ship mode, ATTACK_MODE enables fire
//   reload_req     : level request to refill ammo (seen only when idle)
//   ammo_count     : current ammo from the counter
//   ammo_dec       : one-cycle decrement strobe to the counter
//   ammo_load      : one-cycle load strobe to the counter
//   ammo_load_val  : reload value (MAX_AMMO)
//   fire_pulse     : one cycle per shot, aligned with ammo_dec
//   error          : one-cycle illegal-fire flag
//   busy           : high whenever not idle
module fire_controller
   import weapons_pkg::*;
#(
   parameter int unsigned AMMO_W    = 9,
   parameter int unsigned MAX_AMMO  = MAX_AMMO_DEF,
   parameter int unsigned COOLDOWN  = 3,
   parameter int unsigned BURST     = 3,
   parameter int unsigned RELOAD_CY = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trigger,
   input  logic              burst_mode,
   input  logic [3:0]        mode_selector,
   input  logic              reload_req,
   input  logic [AMMO_W-1:0] ammo_count,
   output logic              ammo_dec,
   output logic              ammo_load,
   output logic [AMMO_W-1:0] ammo_load_val,
   output logic              fire_pulse,
   output logic              error,
   output logic              busy
);

   fc_state_e         state_q;
   logic              trig_q;
   logic [SHOT_W-1:0] shots_left_q;
   logic              ammo_dec_q;
   logic              ammo_load_q;
   logic [AMMO_W-1:0] ammo_load_val_q;
   logic              fire_pulse_q;
   logic              error_q;
   logic              busy_q;

   logic              trig_edge;
   logic              attack;
   logic              has_ammo;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_load_val;
   logic              tmr_en;
   logic              tmr_done;

   assign trig_edge = trigger & ~trig_q;
   assign attack    = (mode_selector == ATTACK_MODE);
   assign has_ammo  = (ammo_count != '0);

   // Timer is armed on leaving FIRE or RELOAD and runs through COOL / RWAIT.
   assign tmr_load     = (state_q == ST_FIRE) || (state_q == ST_RELOAD);
   assign tmr_load_val = (state_q == ST_FIRE) ? TMR_W'(COOLDOWN) : TMR_W'(RELOAD_CY);
   assign tmr_en       = (state_q == ST_COOL) || (state_q == ST_RWAIT);

   cooldown_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .en_i       (tmr_en),
      .done_o     (tmr_done)
   );

   // FSM with Moore outputs registered alongside the state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         trig_q          <= 1'b0;
         shots_left_q    <= '0;
         ammo_dec_q      <= 1'b0;
         ammo_load_q     <= 1'b0;
         ammo_load_val_q <= '0;
         fire_pulse_q    <= 1'b0;
         error_q         <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         trig_q          <= trigger;
         ammo_load_val_q <= AMMO_W'(MAX_AMMO);
         ammo_dec_q      <= 1'b0;
         ammo_load_q     <= 1'b0;
         fire_pulse_q    <= 1'b0;
         error_q         <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               busy_q <= 1'b0;
               // A trigger edge takes priority over a pending reload request.
               if (trig_edge) begin
                  if (attack && has_ammo) begin
                     state_q      <= ST_FIRE;
                     shots_left_q <= burst_mode ? SHOT_W'(BURST) : SHOT_W'(1);
                     fire_pulse_q <= 1'b1;
                     ammo_dec_q   <= 1'b1;
                     busy_q       <= 1'b1;
                  end else begin
                     error_q <= 1'b1;
                  end
               end else if (reload_req) begin
                  state_q     <= ST_RELOAD;
                  ammo_load_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end

            ST_FIRE: begin
               shots_left_q <= shots_left_q - SHOT_W'(1);
               state_q      <= ST_COOL;
               busy_q       <= 1'b1;
            end

            ST_COOL: begin
               busy_q <= 1'b1;
               if (tmr_done) begin
                  if ((shots_left_q != '0) && attack && has_ammo) begin
                     state_q      <= ST_FIRE;
                     fire_pulse_q <= 1'b1;
                     ammo_dec_q   <= 1'b1;
                  end else begin
                     // Running dry mid-burst is illegal; leaving attack is a silent abort.
                     error_q      <= (shots_left_q != '0) && attack;
                     shots_left_q <= '0;
                     state_q      <= ST_IDLE;
                     busy_q       <= 1'b0;
                  end
               end
            end

            ST_RELOAD: begin
               state_q <= ST_RWAIT;
               busy_q  <= 1'b1;
            end

            ST_RWAIT: begin
               busy_q <= 1'b1;
               if (tmr_done) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ammo_dec      = ammo_dec_q;
   assign ammo_load     = ammo_load_q;
   assign ammo_load_val = ammo_load_val_q;
   assign fire_pulse    = fire_pulse_q;
   assign error         = error_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fire_controller.sv
// Self-checking bench for fire_controller: directed scenarios plus random
// stimulus against a schedule-based reference model of the controller.
module tb_fire_controller;

   localparam int unsigned AMMO_W = 9;
   localparam int unsigned MAXA   = 500;
   localparam int unsigned CD     = 3;
   localparam int unsigned NB     = 3;
   localparam int unsigned RCY    = 8;
   localparam logic [3:0]  ATK    = 4'b0010;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              trigger = 1'b0;
   logic              burst_mode = 1'b0;
   logic [3:0]        mode_selector = 4'b0001;
   logic              reload_req = 1'b0;
   logic [AMMO_W-1:0] ammo = '0;
   logic              ammo_dec;
   logic              ammo_load;
   logic [AMMO_W-1:0] ammo_load_val;
   logic              fire_pulse;
   logic              error;
   logic              busy;

   // Environment-side override of the ammo counter.
   logic              ammo_wr = 1'b0;
   logic [AMMO_W-1:0] ammo_wr_val = '0;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   fire_controller #(
      .AMMO_W(AMMO_W), .MAX_AMMO(MAXA), .COOLDOWN(CD), .BURST(NB), .RELOAD_CY(RCY)
   ) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .burst_mode(burst_mode),
      .mode_selector(mode_selector), .reload_req(reload_req), .ammo_count(ammo),
      .ammo_dec(ammo_dec), .ammo_load(ammo_load), .ammo_load_val(ammo_load_val),
      .fire_pulse(fire_pulse), .error(error), .busy(busy)
   );

   // Saturating ammo counter driven by the controller outputs.
   always @(posedge clk) begin
      if (ammo_wr)                       ammo <= ammo_wr_val;
      else if (ammo_load)                ammo <= ammo_load_val;
      else if (ammo_dec && ammo != '0)   ammo <= ammo - AMMO_W'(1);
   end

   // Reference model: an activity (volley or reload) with a relative cycle
   // index; shots land every CD+1 cycles and decisions fall on the last cooldown cycle.
   localparam int ACT_NONE = 0, ACT_SHOOT = 1, ACT_RLD = 2;
   int act = ACT_NONE, rel = 0, fired = 0, total = 0;
   bit prev_trig = 1'b0;
   bit e_fire = 0, e_dec = 0, e_load = 0, e_err = 0, e_busy = 0;
   int e_lv = 0;

   always @(posedge clk) begin
      bit edg, atk;
      e_fire = 0; e_dec = 0; e_load = 0; e_err = 0; e_busy = 0;
      if (rst) begin
         act = ACT_NONE; prev_trig = 1'b0; e_lv = 0;
      end else begin
         edg = trigger && !prev_trig;
         prev_trig = trigger;
         atk = (mode_selector == ATK);
         e_lv = MAXA;
         if (act == ACT_NONE) begin
            if (edg) begin
               if (atk && ammo != 0) begin
                  act = ACT_SHOOT; rel = 0; fired = 1; total = burst_mode ? NB : 1;
                  e_fire = 1; e_dec = 1; e_busy = 1;
               end else e_err = 1;
            end else if (reload_req) begin
               act = ACT_RLD; rel = 0; e_load = 1; e_busy = 1;
            end
         end else if (act == ACT_SHOOT) begin
            if (rel % (CD + 1) == CD) begin
               if (fired < total && atk && ammo != 0) begin
                  fired++; rel++; e_fire = 1; e_dec = 1; e_busy = 1;
               end else begin
                  e_err = (fired < total) && atk;
                  act = ACT_NONE;
               end
            end else begin
               rel++; e_busy = 1;
            end
         end else begin
            if (rel == RCY) act = ACT_NONE;
            else begin rel++; e_busy = 1; end
         end
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Per-scenario observation counters.
   int tick_no = 0;
   int nf = 0, nd = 0, nl = 0, ne = 0, nb = 0, lv_at_load = -1;
   int fire_t[$];

   task automatic clr();
      nf = 0; nd = 0; nl = 0; ne = 0; nb = 0; lv_at_load = -1;
      fire_t.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1 ammo_wr = 1'b0;
      @(negedge clk);
      tick_no++;
      chk("outs", int'({fire_pulse, ammo_dec, ammo_load, error, busy}),
          int'({e_fire, e_dec, e_load, e_err, e_busy}));
      chk("load_val", int'(ammo_load_val), e_lv);
      nf += int'(fire_pulse); nd += int'(ammo_dec); nl += int'(ammo_load);
      ne += int'(error);      nb += int'(busy);
      if (fire_pulse) fire_t.push_back(tick_no);
      if (ammo_load) lv_at_load = int'(ammo_load_val);
   endtask

   task automatic wr_ammo(input int v);
      ammo_wr = 1'b1; ammo_wr_val = AMMO_W'(v);
      tick();
   endtask

   function automatic int gap(input int i);
      if (fire_t.size() > i + 1) return fire_t[i+1] - fire_t[i];
      return -1;
   endfunction

   initial begin
      int t0;
      logic [3:0] modes [4];
      modes[0] = ATK; modes[1] = ATK; modes[2] = 4'b0100; modes[3] = 4'b0001;

      // Reset state
      @(negedge clk);
      rst = 1'b1; tick(); tick();
      chk("rst_outs", int'({fire_pulse, ammo_dec, ammo_load, error, busy}), 0);
      chk("rst_lv", int'(ammo_load_val), 0);

      // 1. Single shot, trigger held
      rst = 1'b0; mode_selector = ATK; burst_mode = 1'b0; trigger = 1'b0;
      wr_ammo(500);
      clr(); t0 = tick_no; trigger = 1'b1;
      repeat (20) tick();
      chk("s1_fires", nf, 1);
      chk("s1_latency", (fire_t.size() > 0) ? fire_t[0] - t0 : -1, 1);
      chk("s1_busy", nb, 1 + CD);
      chk("s1_err", ne, 0);

      // 2. Burst of three from 500
      trigger = 1'b0; burst_mode = 1'b1;
      wr_ammo(500);
      clr(); trigger = 1'b1;
      repeat (20) tick();
      chk("s2_fires", nf, 3);
      chk("s2_gap0", gap(0), CD + 1);
      chk("s2_gap1", gap(1), CD + 1);
      chk("s2_ammo", int'(ammo), 497);

      // 3. Running empty mid-burst
      trigger = 1'b0;
      wr_ammo(2);
      clr(); trigger = 1'b1;
      repeat (20) tick();
      chk("s3_fires", nf, 2);
      chk("s3_err", ne, 1);
      chk("s3_ammo", int'(ammo), 0);
      chk("s3_idle", int'(busy), 0);

      // 4a. Wrong mode: held trigger gives one error, no decrement
      trigger = 1'b0; mode_selector = 4'b0100;
      wr_ammo(500);
      clr(); trigger = 1'b1;
      repeat (5) tick();
      chk("s4_dec", nd, 0);
      chk("s4_err", ne, 1);
      // 4b. Mode leaves attack during cooldown: silent abort
      trigger = 1'b0; mode_selector = ATK; burst_mode = 1'b1;
      tick();
      clr(); trigger = 1'b1;
      tick(); tick();
      mode_selector = 4'b0001;
      repeat (18) tick();
      chk("s4_abort_fires", nf, 1);
      chk("s4_abort_err", ne, 0);

      // 5. Reload from empty; trigger edge during the wait is ignored
      trigger = 1'b0; mode_selector = ATK;
      wr_ammo(0);
      clr(); reload_req = 1'b1;
      tick();
      reload_req = 1'b0;
      repeat (3) tick();
      trigger = 1'b1;
      repeat (12) tick();
      chk("s5_loads", nl, 1);
      chk("s5_lv", lv_at_load, 500);
      chk("s5_busy", nb, 1 + RCY);
      chk("s5_fires", nf, 0);
      chk("s5_ammo", int'(ammo), 500);

      // 6. Reset during cooldown, then a fresh burst
      trigger = 1'b0; burst_mode = 1'b1;
      tick();
      trigger = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("s6_rst_outs", int'({fire_pulse, ammo_dec, ammo_load, error, busy}), 0);
      rst = 1'b0; trigger = 1'b0;
      tick();
      clr(); trigger = 1'b1;
      repeat (20) tick();
      chk("s6_fires", nf, 3);

      // Random stimulus against the model
      repeat (3000) begin
         if ($urandom_range(0, 3) == 0) trigger = ~trigger;
         if ($urandom_range(0, 15) == 0) burst_mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 31) == 0) mode_selector = modes[$urandom_range(0, 3)];
         reload_req = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 39) == 0) begin
            ammo_wr = 1'b1; ammo_wr_val = AMMO_W'($urandom_range(0, 4));
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
